// File: rtl/ahb_xfer_capture.sv
// Passive AHB-Lite slave-port monitor: pairs address and data phases, checks
// burst/response protocol and queues completed transfer records in a FWFT FIFO.
module ahb_xfer_capture #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          hsel,
  input  logic [ADDR_WIDTH-1:0]         haddr,
  input  logic [1:0]                    htrans,
  input  logic                          hwrite,
  input  logic [2:0]                    hsize,
  input  logic [2:0]                    hburst,
  input  logic [DATA_WIDTH-1:0]         hwdata,
  input  logic [DATA_WIDTH-1:0]         hrdata,
  input  logic                          hready,
  input  logic                          hresp,
  output logic                          rec_valid,
  input  logic                          rec_ready,
  output logic [ADDR_WIDTH-1:0]         rec_addr,
  output logic [DATA_WIDTH-1:0]         rec_data,
  output logic                          rec_write,
  output logic [2:0]                    rec_size,
  output logic                          rec_resp,
  output logic                          rec_perr,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [15:0]                   drop_count,
  output logic                          proto_err
);

  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int CW    = PW + 1;
  localparam int REC_W = ADDR_WIDTH + DATA_WIDTH + 7;
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [2:0]    MAX_SIZE = 3'($clog2(DATA_WIDTH / 8));

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DATA = 2'd1;
  localparam logic [1:0] S_ERR  = 2'd2;

  logic [1:0]            r_state, w_state_next;
  logic [ADDR_WIDTH-1:0] r_paddr;
  logic                  r_pwrite, r_pperr;
  logic [2:0]            r_psize;

  logic                  r_open;
  logic [ADDR_WIDTH-1:0] r_prev;
  logic [2:0]            r_bburst, r_bsize;
  logic                  r_bwrite;
  logic [4:0]            r_beats;

  logic [REC_W-1:0]      r_mem [FIFO_DEPTH];
  logic [PW-1:0]         r_wptr, r_rptr;
  logic [CW-1:0]         r_count;
  logic [15:0]           r_drop;
  logic                  r_proto;

  logic                  w_accept, w_is_seq, w_size_err, w_seq_err, w_perr_cand;
  logic                  w_fixed, w_wrap;
  logic [4:0]            w_len;
  logic [ADDR_WIDTH-1:0] w_incr, w_mask, w_expect;
  logic                  w_complete, w_resp, w_cperr, w_viol;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  w_full, w_push, w_pop;
  logic [REC_W-1:0]      w_rec, w_head;

  assign w_accept = hsel & htrans[1] & hready;
  assign w_is_seq = (htrans == 2'b11);

  // Burst length and address expectation derive from the burst's opening beat.
  always_comb begin
    w_len = 5'd0;
    case (r_bburst)
      3'd2, 3'd3: w_len = 5'd4;
      3'd4, 3'd5: w_len = 5'd8;
      3'd6, 3'd7: w_len = 5'd16;
      default:    w_len = 5'd0;
    endcase
  end

  assign w_fixed  = (r_bburst >= 3'd2);
  assign w_wrap   = w_fixed & ~r_bburst[0];
  assign w_incr   = r_prev + (ADDR_WIDTH'(1) << r_bsize);
  assign w_mask   = (ADDR_WIDTH'(w_len) << r_bsize) - ADDR_WIDTH'(1);
  assign w_expect = w_wrap ? ((r_prev & ~w_mask) | (w_incr & w_mask)) : w_incr;

  assign w_size_err = (hsize > MAX_SIZE);
  assign w_seq_err  = ~r_open | (r_bburst == 3'd0) | (w_fixed & (r_beats >= w_len)) |
                      (haddr != w_expect) | (hburst != r_bburst) |
                      (hwrite != r_bwrite) | (hsize != r_bsize);
  assign w_perr_cand = w_size_err | (w_is_seq & w_seq_err);

  always_comb begin
    w_state_next = r_state;
    w_complete   = 1'b0;
    w_resp       = 1'b0;
    w_cperr      = 1'b0;
    w_viol       = 1'b0;
    case (r_state)
      S_IDLE: if (w_accept) w_state_next = S_DATA;
      S_DATA: begin
        if (hready) begin
          w_complete   = 1'b1;
          w_resp       = hresp;
          w_cperr      = r_pperr | hresp;
          w_viol       = hresp;
          w_state_next = w_accept ? S_DATA : S_IDLE;
        end else if (hresp) begin
          w_state_next = S_ERR;
        end
      end
      S_ERR: begin
        // Second ERROR cycle must keep hresp high; OKAY here is a violation.
        if (hready) begin
          w_complete   = 1'b1;
          w_resp       = 1'b1;
          w_cperr      = r_pperr | ~hresp;
          w_viol       = ~hresp;
          w_state_next = w_accept ? S_DATA : S_IDLE;
        end else if (!hresp) begin
          w_viol = 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign w_data = r_pwrite ? hwdata : hrdata;
  assign w_rec  = {r_paddr, w_data, r_pwrite, r_psize, w_resp, w_cperr};

  assign w_full = (r_count == DEPTH_C);
  assign w_pop  = (r_count != '0) & rec_ready;
  assign w_push = w_complete & (~w_full | w_pop);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_paddr  <= '0;
      r_pwrite <= 1'b0;
      r_psize  <= 3'd0;
      r_pperr  <= 1'b0;
      r_open   <= 1'b0;
      r_prev   <= '0;
      r_bburst <= 3'd0;
      r_bsize  <= 3'd0;
      r_bwrite <= 1'b0;
      r_beats  <= 5'd0;
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_drop   <= 16'd0;
      r_proto  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_paddr  <= haddr;
        r_pwrite <= hwrite;
        r_psize  <= hsize;
        r_pperr  <= w_perr_cand;
      end else if (r_state == S_ERR && w_viol) begin
        r_pperr <= 1'b1;
      end

      if (w_accept) begin
        r_prev <= haddr;
        if (!w_is_seq) begin
          r_open   <= 1'b1;
          r_beats  <= 5'd1;
          r_bburst <= hburst;
          r_bsize  <= hsize;
          r_bwrite <= hwrite;
        end else if (r_beats != 5'h1f) begin
          r_beats <= r_beats + 5'd1;
        end
      end else if (hsel && hready && htrans == 2'b00) begin
        r_open <= 1'b0;
      end

      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase

      if (w_complete && w_full && !w_pop && r_drop != 16'hFFFF)
        r_drop <= r_drop + 16'd1;

      r_proto <= r_proto | (w_accept & w_perr_cand) | w_viol | (w_complete & w_cperr);
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wptr] <= w_rec;
  end

  assign rec_valid  = (r_count != '0);
  assign w_head     = rec_valid ? r_mem[r_rptr] : '0;
  assign {rec_addr, rec_data, rec_write, rec_size, rec_resp, rec_perr} = w_head;
  assign fifo_count = r_count;
  assign drop_count = r_drop;
  assign proto_err  = r_proto;

endmodule

// File: tb/tb_ahb_xfer_capture.sv
// Directed bench for ahb_xfer_capture: hand-computed records for single, burst,
// error-response, FIFO-overflow and reset-mid-transfer scenarios.
module tb_ahb_xfer_capture;

  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_NS   = 2'b10;
  localparam logic [1:0] T_SEQ  = 2'b11;

  logic        clock = 1'b0;
  logic        reset;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hready;
  logic        hresp;
  logic        rec_valid;
  logic        rec_ready;
  logic [31:0] rec_addr;
  logic [31:0] rec_data;
  logic        rec_write;
  logic [2:0]  rec_size;
  logic        rec_resp;
  logic        rec_perr;
  logic [3:0]  fifo_count;
  logic [15:0] drop_count;
  logic        proto_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  ahb_xfer_capture #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .FIFO_DEPTH(8)) dut (
    .clock(clock), .reset(reset), .hsel(hsel), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata), .hrdata(hrdata),
    .hready(hready), .hresp(hresp), .rec_valid(rec_valid), .rec_ready(rec_ready),
    .rec_addr(rec_addr), .rec_data(rec_data), .rec_write(rec_write), .rec_size(rec_size),
    .rec_resp(rec_resp), .rec_perr(rec_perr), .fifo_count(fifo_count),
    .drop_count(drop_count), .proto_err(proto_err)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  // One bus cycle: apply inputs, clock once, settle 1 time unit after the edge.
  task automatic bus(input logic sel, input logic [1:0] trans, input logic [31:0] addr,
                     input logic wr, input logic [2:0] burst, input logic [31:0] wdata,
                     input logic [31:0] rdata, input logic rdy, input logic resp);
    hsel = sel; htrans = trans; haddr = addr; hwrite = wr; hburst = burst;
    hwdata = wdata; hrdata = rdata; hready = rdy; hresp = resp;
    @(posedge clock);
    #1;
  endtask

  task automatic pop_rec(input string tag, input logic [31:0] addr, input logic [31:0] data,
                         input logic wr, input logic resp, input logic perr);
    check_eq({tag, ".valid"}, 64'(rec_valid), 64'(1));
    check_eq({tag, ".addr"},  64'(rec_addr),  64'(addr));
    check_eq({tag, ".data"},  64'(rec_data),  64'(data));
    check_eq({tag, ".write"}, 64'(rec_write), 64'(wr));
    check_eq({tag, ".size"},  64'(rec_size),  64'(2));
    check_eq({tag, ".resp"},  64'(rec_resp),  64'(resp));
    check_eq({tag, ".perr"},  64'(rec_perr),  64'(perr));
    rec_ready = 1'b1;
    bus(1'b0, T_IDLE, 32'h0, 1'b0, 3'd0, 32'h0, 32'h0, 1'b1, 1'b0);
    rec_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; rec_ready = 1'b0; hsel = 1'b0; htrans = T_IDLE; haddr = 32'h0;
    hwrite = 1'b0; hsize = 3'd2; hburst = 3'd0; hwdata = 32'h0; hrdata = 32'h0;
    hready = 1'b1; hresp = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    check_eq("rst.valid", 64'(rec_valid),  64'(0));
    check_eq("rst.count", 64'(fifo_count), 64'(0));
    check_eq("rst.drop",  64'(drop_count), 64'(0));
    check_eq("rst.perr",  64'(proto_err),  64'(0));
    check_eq("rst.addr",  64'(rec_addr),   64'(0));

    // Single write
    bus(1'b1, T_NS, 32'h100, 1'b1, 3'd0, 32'h0, 32'h0, 1'b1, 1'b0);
    check_eq("t1.valid_pre", 64'(rec_valid), 64'(0));
    bus(1'b1, T_IDLE, 32'h0, 1'b0, 3'd0, 32'hDEADBEEF, 32'h0, 1'b1, 1'b0);
    pop_rec("t1", 32'h100, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0);
    check_eq("t1.empty", 64'(rec_valid), 64'(0));

    // INCR4 read, two wait states on beat 2
    bus(1'b1, T_NS,  32'h20, 1'b0, 3'd3, 32'h0, 32'h0, 1'b1, 1'b0);
    bus(1'b1, T_SEQ, 32'h24, 1'b0, 3'd3, 32'h0, 32'h1, 1'b1, 1'b0);
    bus(1'b1, T_SEQ, 32'h28, 1'b0, 3'd3, 32'h0, 32'hBAD, 1'b0, 1'b0);
    bus(1'b1, T_SEQ, 32'h28, 1'b0, 3'd3, 32'h0, 32'hBAD, 1'b0, 1'b0);
    bus(1'b1, T_SEQ, 32'h28, 1'b0, 3'd3, 32'h0, 32'h2, 1'b1, 1'b0);
    bus(1'b1, T_SEQ, 32'h2C, 1'b0, 3'd3, 32'h0, 32'h3, 1'b1, 1'b0);
    bus(1'b1, T_IDLE, 32'h0, 1'b0, 3'd0, 32'h0, 32'h4, 1'b1, 1'b0);
    check_eq("t2.count", 64'(fifo_count), 64'(4));
    for (int i = 0; i < 4; i++)
      pop_rec($sformatf("t2.b%0d", i), 32'h20 + 32'(4 * i), 32'(i + 1), 1'b0, 1'b0, 1'b0);
    check_eq("t2.proto", 64'(proto_err), 64'(0));

    // WRAP4 at 0x38: 0x38, 0x3C, 0x30, 0x34
    bus(1'b1, T_NS,  32'h38, 1'b1, 3'd2, 32'h0,  32'h0, 1'b1, 1'b0);
    bus(1'b1, T_SEQ, 32'h3C, 1'b1, 3'd2, 32'hA0, 32'h0, 1'b1, 1'b0);
    bus(1'b1, T_SEQ, 32'h30, 1'b1, 3'd2, 32'hA1, 32'h0, 1'b1, 1'b0);
    bus(1'b1, T_SEQ, 32'h34, 1'b1, 3'd2, 32'hA2, 32'h0, 1'b1, 1'b0);
    bus(1'b1, T_IDLE, 32'h0, 1'b0, 3'd0, 32'hA3, 32'h0, 1'b1, 1'b0);
    pop_rec("t3.w0", 32'h38, 32'hA0, 1'b1, 1'b0, 1'b0);
    pop_rec("t3.w1", 32'h3C, 32'hA1, 1'b1, 1'b0, 1'b0);
    pop_rec("t3.w2", 32'h30, 32'hA2, 1'b1, 1'b0, 1'b0);
    pop_rec("t3.w3", 32'h34, 32'hA3, 1'b1, 1'b0, 1'b0);
    check_eq("t3.proto_clean", 64'(proto_err), 64'(0));
    bus(1'b1, T_NS,  32'h38, 1'b1, 3'd2, 32'h0,  32'h0, 1'b1, 1'b0);
    bus(1'b1, T_SEQ, 32'h40, 1'b1, 3'd2, 32'hB0, 32'h0, 1'b1, 1'b0);
    bus(1'b1, T_IDLE, 32'h0, 1'b0, 3'd0, 32'hB1, 32'h0, 1'b1, 1'b0);
    check_eq("t3.proto_bad", 64'(proto_err), 64'(1));
    pop_rec("t3.b0", 32'h38, 32'hB0, 1'b1, 1'b0, 1'b0);
    pop_rec("t3.b1", 32'h40, 32'hB1, 1'b1, 1'b0, 1'b1);

    // Error responses: two-cycle, single-cycle, and ERR followed by OKAY
    bus(1'b1, T_NS,   32'h200, 1'b0, 3'd0, 32'h0, 32'h0,  1'b1, 1'b0);
    bus(1'b1, T_IDLE, 32'h0,   1'b0, 3'd0, 32'h0, 32'h0,  1'b0, 1'b1);
    bus(1'b1, T_IDLE, 32'h0,   1'b0, 3'd0, 32'h0, 32'h55, 1'b1, 1'b1);
    bus(1'b1, T_NS,   32'h204, 1'b0, 3'd0, 32'h0, 32'h0,  1'b1, 1'b0);
    bus(1'b1, T_IDLE, 32'h0,   1'b0, 3'd0, 32'h0, 32'h66, 1'b1, 1'b1);
    bus(1'b1, T_NS,   32'h208, 1'b0, 3'd0, 32'h0, 32'h0,  1'b1, 1'b0);
    bus(1'b1, T_IDLE, 32'h0,   1'b0, 3'd0, 32'h0, 32'h0,  1'b0, 1'b1);
    bus(1'b1, T_IDLE, 32'h0,   1'b0, 3'd0, 32'h0, 32'h77, 1'b1, 1'b0);
    check_eq("t4.count", 64'(fifo_count), 64'(3));
    pop_rec("t4.err2", 32'h200, 32'h55, 1'b0, 1'b1, 1'b0);
    pop_rec("t4.err1", 32'h204, 32'h66, 1'b0, 1'b1, 1'b1);
    pop_rec("t4.errv", 32'h208, 32'h77, 1'b0, 1'b1, 1'b1);

    // Ten back-to-back writes into an 8-deep FIFO with no consumer
    for (int i = 0; i < 10; i++)
      bus(1'b1, T_NS, 32'h300 + 32'(4 * i), 1'b1, 3'd0,
          (i == 0) ? 32'h0 : 32'h1000 + 32'(i - 1), 32'h0, 1'b1, 1'b0);
    bus(1'b1, T_IDLE, 32'h0, 1'b0, 3'd0, 32'h1009, 32'h0, 1'b1, 1'b0);
    check_eq("t5.count", 64'(fifo_count), 64'(8));
    check_eq("t5.drop",  64'(drop_count), 64'(2));
    for (int i = 0; i < 8; i++)
      pop_rec($sformatf("t5.r%0d", i), 32'h300 + 32'(4 * i), 32'h1000 + 32'(i), 1'b1, 1'b0, 1'b0);
    check_eq("t5.empty", 64'(rec_valid), 64'(0));

    // Reset during a wait state of a pending read
    bus(1'b1, T_NS, 32'h400, 1'b0, 3'd0, 32'h0, 32'h0, 1'b1, 1'b0);
    reset = 1'b1;
    bus(1'b1, T_IDLE, 32'h0, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    check_eq("t6.valid", 64'(rec_valid),  64'(0));
    check_eq("t6.count", 64'(fifo_count), 64'(0));
    check_eq("t6.drop",  64'(drop_count), 64'(0));
    check_eq("t6.proto", 64'(proto_err),  64'(0));
    check_eq("t6.data",  64'(rec_data),   64'(0));
    reset = 1'b0;
    bus(1'b1, T_IDLE, 32'h0, 1'b0, 3'd0, 32'h0, 32'hAB, 1'b1, 1'b0);
    bus(1'b1, T_IDLE, 32'h0, 1'b0, 3'd0, 32'h0, 32'hAB, 1'b1, 1'b0);
    check_eq("t6.no_rec", 64'(rec_valid), 64'(0));
    bus(1'b1, T_SEQ,  32'h404, 1'b0, 3'd0, 32'h0, 32'h0,  1'b1, 1'b0);
    bus(1'b1, T_IDLE, 32'h0,   1'b0, 3'd0, 32'h0, 32'h99, 1'b1, 1'b0);
    check_eq("t6.proto_seq", 64'(proto_err), 64'(1));
    pop_rec("t6.seq", 32'h404, 32'h99, 1'b0, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
